// File: rtl/unified_mem.sv
// Unified instruction/data word memory for a multicycle datapath.
// Define MEM_WAIT_EN to add WAIT_CYCLES wait states per access.
module unified_mem #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

`ifdef MEM_WAIT_EN
  localparam int unsigned CW =
    (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  localparam state_t S_FIRST =
    (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;

  logic [CW-1:0] cnt;
`else
  typedef enum logic [0:0] {
    S_IDLE,
    S_RESP
  } state_t;

  localparam state_t S_FIRST = S_RESP;
`endif

  state_t state;
  state_t state_d;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic [31:0] rdata_q;
  logic [29:0] widx;
  logic        fault;
  logic        accept;
  logic        rd_resp;
  logic [31:0] rd_word;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept = (state == S_IDLE) && req;

  // Modular subtraction lets addresses below BASE_ADDR wrap out of range.
  assign widx  = 30'((addr_q - BASE_ADDR) >> 2);
  assign fault = (addr_q[1:0] != 2'b00) ||
                 ({2'b00, widx} >= 32'(DEPTH_WORDS));

  assign rd_resp = (state == S_RESP) && !we_q;
  assign rd_word = fault ? 32'h0 : mem[widx[AW-1:0]];

  assign ready = (state == S_RESP);
  assign err   = ready && fault;
  assign rdata = rd_resp ? rd_word : rdata_q;

  always_comb begin
    state_d = state;
    unique case (state)
      S_IDLE: if (req) state_d = S_FIRST;
`ifdef MEM_WAIT_EN
      S_WAIT: if (cnt == '0) state_d = S_RESP;
`endif
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

`ifdef MEM_WAIT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_INIT;
    end else if (state == S_WAIT && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (accept) begin
      addr_q  <= addr;
      wdata_q <= wdata;
      we_q    <= we;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (rd_resp) begin
      rdata_q <= rd_word;
    end
  end

  // Storage is never reset; an aborted write never reaches this edge in RESP.
  always_ff @(posedge clk) begin
    if (!reset && state == S_RESP && we_q && !fault) begin
      mem[widx[AW-1:0]] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_unified_mem.sv
// Random and directed bench for unified_mem against a word-array model.
// Latency expectation follows the MEM_WAIT_EN build setting.
module tb_unified_mem;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned WC    = 2;
`ifdef MEM_WAIT_EN
  localparam int LAT = 1 + WC;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        reset;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        err;

  int total;
  int bad;

  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;

  unified_mem #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE),
    .WAIT_CYCLES(WC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .req  (req),
    .we   (we),
    .addr (addr),
    .wdata(wdata),
    .rdata(rdata),
    .ready(ready),
    .err  (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    logic [31:0] a;
    k = $urandom_range(0, 9);
    a = 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (k == 7) a = a | 32'($urandom_range(1, 3));
    else if (k == 8) a = 32'h400 + (32'($urandom_range(0, 1000)) << 2);
    else if (k == 9) a = ($urandom & 32'hFFFF_FFFC) | 32'h8000_0000;
    return a;
  endfunction

  // One access: drive at a falling edge, expect ready exactly LAT cycles on.
  task automatic access(input bit w, input logic [31:0] a,
                        input logic [31:0] d, input bit junk);
    logic [31:0] off;
    int unsigned idx;
    bit flt;
    logic [31:0] exp;
    off = a - BASE;
    idx = off >> 2;
    flt = (a % 4 != 0) || (idx >= DEPTH);
    exp = w ? last_rd : (flt ? 32'h0 : model[idx]);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c < LAT) begin
        check("early_ready", {31'b0, ready}, 32'h0);
        req   = junk ? 1'($urandom_range(0, 1)) : 1'b0;
        we    = 1'($urandom_range(0, 1));
        addr  = $urandom;
        wdata = $urandom;
      end else begin
        check("ready", {31'b0, ready}, 32'h1);
        check("err", {31'b0, err}, {31'b0, flt});
        check("rdata", rdata, exp);
        req = 1'b0;
      end
    end
    if (w && !flt) model[idx] = d;
    if (!w) last_rd = exp;
    @(negedge clk);
    check("idle_after", {31'b0, ready}, 32'h0);
    check("rdata_hold", rdata, last_rd);
  endtask

  logic [31:0] saddr [10];

  initial begin
    total   = 0;
    bad     = 0;
    last_rd = 32'h0;
    reset   = 1'b1;
    req     = 1'b0;
    we      = 1'b0;
    addr    = 32'h0;
    wdata   = 32'h0;

    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++)
      access(1'b1, BASE + 32'(i) * 4, $urandom, 1'b0);

    access(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    access(1'b0, 32'h10, 32'h0, 1'b0);
    check("dir_beef", rdata, 32'hDEAD_BEEF);

    access(1'b0, 32'h13, 32'h0, 1'b0);
    access(1'b1, 32'h400, 32'h5, 1'b0);
    access(1'b0, 32'h0, 32'h0, 1'b0);
    access(1'b0, 32'h3FC, 32'h0, 1'b0);
    access(1'b0, 32'h12, 32'h0, 1'b1);

    access(1'b0, 32'h40, 32'h0, 1'b1);

    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    req   = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, ready}, 32'h0);
    check("abort_rdata", rdata, 32'h0);
    reset   = 1'b0;
    last_rd = 32'h0;
    for (int c = 0; c < LAT + 2; c++) begin
      @(negedge clk);
      check("abort_quiet", {31'b0, ready}, 32'h0);
    end
    access(1'b0, 32'h20, 32'h0, 1'b0);

    for (int i = 0; i < 60; i++)
      access(1'($urandom_range(0, 1)), rand_addr(), $urandom,
             1'($urandom_range(0, 1)));

    for (int k = 0; k < 10; k++)
      saddr[k] = 32'($urandom_range(0, DEPTH - 1)) << 2;
    @(negedge clk);
    req = 1'b1; we = 1'b0; addr = saddr[0];
    for (int k = 0; k < 10; k++) begin
      for (int c = 1; c <= LAT; c++) begin
        @(negedge clk);
        if (c < LAT) begin
          check("strm_early", {31'b0, ready}, 32'h0);
        end else begin
          check("strm_ready", {31'b0, ready}, 32'h1);
          check("strm_err", {31'b0, err}, 32'h0);
          check("strm_rdata", rdata, model[saddr[k] >> 2]);
          last_rd = model[saddr[k] >> 2];
          if (k < 9) addr = saddr[k + 1];
          else req = 1'b0;
        end
      end
      @(negedge clk);
      check("strm_gap", {31'b0, ready}, 32'h0);
    end

    for (int i = 0; i < 8; i++)
      access(1'b0, 32'($urandom_range(0, DEPTH - 1)) << 2, 32'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
